// File: rtl/bank_wr_hold.sv
// Write-hold stage ahead of the two-bank selector: reads always win a bank conflict, colliding
// writes are queued and retired in order, and reads of a pending address get the queued data.
module bank_wr_hold #(
   parameter int unsigned A_W   = 10,
   parameter int unsigned D_W   = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       RD_EN,
   input  logic [A_W-1:0]             RD_ADR,
   input  logic                       WR_EN,
   input  logic [A_W-1:0]             WR_ADR,
   input  logic [D_W-1:0]             WR_DATA,
   output logic                       WR_RDY,
   output logic                       RE_N,
   output logic [A_W-1:0]             R_ADR,
   output logic                       WE_N,
   output logic [A_W-1:0]             W_ADR,
   output logic [D_W-1:0]             W_DATA,
   output logic                       FWD_VALID,
   output logic [D_W-1:0]             FWD_DATA,
   output logic [$clog2(DEPTH):0]     PEND_CNT,
   output logic                       OVF_ERR
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [A_W-1:0] r_adr_mem [DEPTH];
   logic [D_W-1:0] r_dat_mem [DEPTH];
   logic [PW-1:0]  r_wptr;
   logic [PW-1:0]  r_rptr;
   logic [CW-1:0]  r_cnt;

   logic           r_re;
   logic [A_W-1:0] r_r_adr;
   logic           r_we;
   logic [A_W-1:0] r_w_adr;
   logic [D_W-1:0] r_w_dat;
   logic           r_fwd_vld;
   logic [D_W-1:0] r_fwd_dat;
   logic           r_ovf;

   logic           w_rdy;
   logic           w_acc;
   logic           w_empty;
   logic           w_cand_vld;
   logic [A_W-1:0] w_cand_adr;
   logic [D_W-1:0] w_cand_dat;
   logic           w_issue;
   logic           w_push;
   logic           w_pop;
   logic [CW-1:0]  w_cnt_nxt;
   logic           w_hit;
   logic [D_W-1:0] w_hit_dat;
   logic [PW-1:0]  w_idx;

   assign w_rdy   = (r_cnt < CW'(DEPTH));
   assign w_acc   = WR_EN & w_rdy;
   assign w_empty = (r_cnt == '0);

   // The buffer head always goes first so an incoming write can never overtake it.
   assign w_cand_vld = ~w_empty | w_acc;
   assign w_cand_adr = w_empty ? WR_ADR  : r_adr_mem[r_rptr];
   assign w_cand_dat = w_empty ? WR_DATA : r_dat_mem[r_rptr];

   assign w_issue   = w_cand_vld & (~RD_EN | (w_cand_adr[0] != RD_ADR[0]));
   assign w_pop     = w_issue & ~w_empty;
   assign w_push    = w_acc & ~(w_issue & w_empty);
   assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

   // Scan oldest to youngest so the last match wins; the same-cycle write is youngest of all.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_dat = '0;
      w_idx     = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_idx = r_rptr + PW'(i);
         if ((CW'(i) < r_cnt) && (r_adr_mem[w_idx] == RD_ADR)) begin
            w_hit     = 1'b1;
            w_hit_dat = r_dat_mem[w_idx];
         end
      end
      if (w_acc && (WR_ADR == RD_ADR)) begin
         w_hit     = 1'b1;
         w_hit_dat = WR_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_adr_mem[r_wptr] <= WR_ADR;
         r_dat_mem[r_wptr] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_cnt     <= '0;
         r_re      <= 1'b0;
         r_r_adr   <= '0;
         r_we      <= 1'b0;
         r_w_adr   <= '0;
         r_w_dat   <= '0;
         r_fwd_vld <= 1'b0;
         r_fwd_dat <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_cnt <= w_cnt_nxt;
         r_re  <= RD_EN;
         if (RD_EN) r_r_adr <= RD_ADR;
         r_we <= w_issue;
         if (w_issue) begin
            r_w_adr <= w_cand_adr;
            r_w_dat <= w_cand_dat;
         end
         r_fwd_vld <= RD_EN & w_hit;
         if (RD_EN && w_hit) r_fwd_dat <= w_hit_dat;
         if (WR_EN && !w_rdy) r_ovf <= 1'b1;
      end
   end

   assign WR_RDY    = w_rdy;
   assign RE_N      = r_re;
   assign R_ADR     = r_r_adr;
   assign WE_N      = r_we;
   assign W_ADR     = r_w_adr;
   assign W_DATA    = r_w_dat;
   assign FWD_VALID = r_fwd_vld;
   assign FWD_DATA  = r_fwd_dat;
   assign PEND_CNT  = r_cnt;
   assign OVF_ERR   = r_ovf;

endmodule

// File: tb/tb_bank_wr_hold.sv
// Randomized and directed bench for bank_wr_hold; expected outputs come from a queue-based model
// and are checked by an independent monitor one cycle after each request.
module tb_bank_wr_hold;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0;
   logic [9:0]  rd_adr = '0;
   logic        wr_en = 1'b0;
   logic [9:0]  wr_adr = '0;
   logic [31:0] wr_data = '0;
   logic        wr_rdy, re_n, we_n, fwd_valid, ovf_err;
   logic [9:0]  r_adr, w_adr;
   logic [31:0] w_data, fwd_data;
   logic [2:0]  pend_cnt;

   bank_wr_hold #(.A_W(10), .D_W(32), .DEPTH(DEPTH)) dut (
      .CLK(clk), .RST_N(rst_n), .RD_EN(rd_en), .RD_ADR(rd_adr), .WR_EN(wr_en),
      .WR_ADR(wr_adr), .WR_DATA(wr_data), .WR_RDY(wr_rdy), .RE_N(re_n), .R_ADR(r_adr),
      .WE_N(we_n), .W_ADR(w_adr), .W_DATA(w_data), .FWD_VALID(fwd_valid),
      .FWD_DATA(fwd_data), .PEND_CNT(pend_cnt), .OVF_ERR(ovf_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0]  adr;
      logic [31:0] data;
   } pw_t;

   typedef struct packed {
      logic        re;
      logic [9:0]  r_adr;
      logic        we;
      logic [9:0]  w_adr;
      logic [31:0] w_data;
      logic        fv;
      logic [31:0] fd;
      logic [2:0]  cnt;
      logic        rdy;
      logic        ovf;
   } exp_t;

   pw_t  pend[$];
   exp_t sb[$];
   exp_t m;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      m = '0;
      m.rdy = 1'b1;
   endtask

   // Apply one request and record what the outputs must look like after the next edge.
   task automatic drive(input logic re, input logic [9:0] ra, input logic we,
                        input logic [9:0] wa, input logic [31:0] wd);
      logic acc, hit, has_c, iss;
      logic [31:0] hd;
      pw_t c;
      rd_en = re; rd_adr = ra; wr_en = we; wr_adr = wa; wr_data = wd;
      acc = we && (pend.size() < DEPTH);
      if (we && !acc) m.ovf = 1'b1;
      hit = 1'b0;
      hd  = '0;
      foreach (pend[i]) if (pend[i].adr == ra) begin hit = 1'b1; hd = pend[i].data; end
      if (acc && wa == ra) begin hit = 1'b1; hd = wd; end
      has_c = (pend.size() > 0) || acc;
      c = (pend.size() > 0) ? pend[0] : pw_t'{adr: wa, data: wd};
      iss = has_c && (!re || (c.adr[0] != ra[0]));
      if (acc) pend.push_back(pw_t'{adr: wa, data: wd});
      if (iss) void'(pend.pop_front());
      m.re = re;
      if (re) m.r_adr = ra;
      m.we = iss;
      if (iss) begin m.w_adr = c.adr; m.w_data = c.data; end
      m.fv = re && hit;
      if (re && hit) m.fd = hd;
      m.cnt = 3'(pend.size());
      m.rdy = pend.size() < DEPTH;
      sb.push_back(m);
   endtask

   task automatic cyc(input logic re, input logic [9:0] ra, input logic we,
                      input logic [9:0] wa, input logic [31:0] wd);
      @(posedge clk);
      #2;
      drive(re, ra, we, wa, wd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 10'h0, 1'b0, 10'h0, 32'h0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_re", 64'(re_n), 64'(0));
      chk("rst_we", 64'(we_n), 64'(0));
      chk("rst_r_adr", 64'(r_adr), 64'(0));
      chk("rst_w_adr", 64'(w_adr), 64'(0));
      chk("rst_w_data", 64'(w_data), 64'(0));
      chk("rst_fwd_valid", 64'(fwd_valid), 64'(0));
      chk("rst_fwd_data", 64'(fwd_data), 64'(0));
      chk("rst_pend_cnt", 64'(pend_cnt), 64'(0));
      chk("rst_wr_rdy", 64'(wr_rdy), 64'(1));
      chk("rst_ovf", 64'(ovf_err), 64'(0));
   endtask

   task automatic random_cycles(input int n);
      for (int i = 0; i < n; i++)
         cyc(($urandom_range(0, 9) < 6), 10'($urandom_range(0, 31)),
             ($urandom_range(0, 9) < 5), 10'($urandom_range(0, 31)), $urandom);
   endtask

   // Monitor: one expected record per clock once requests start.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("re_n", 64'(re_n), 64'(e.re));
            chk("r_adr", 64'(r_adr), 64'(e.r_adr));
            chk("we_n", 64'(we_n), 64'(e.we));
            chk("w_adr", 64'(w_adr), 64'(e.w_adr));
            chk("w_data", 64'(w_data), 64'(e.w_data));
            chk("fwd_valid", 64'(fwd_valid), 64'(e.fv));
            if (e.fv) chk("fwd_data", 64'(fwd_data), 64'(e.fd));
            chk("pend_cnt", 64'(pend_cnt), 64'(e.cnt));
            chk("wr_rdy", 64'(wr_rdy), 64'(e.rdy));
            chk("ovf_err", 64'(ovf_err), 64'(e.ovf));
         end
      end
   end

   initial begin
      model_reset();
      #3;
      chk_reset_outputs();
      #9 rst_n = 1'b1;

      // Different-bank accept, then same-bank hold followed by a retire.
      cyc(1'b1, 10'h005, 1'b1, 10'h00A, 32'h1111);
      cyc(1'b1, 10'h004, 1'b1, 10'h006, 32'h2222);
      idle(1);
      // Fill to DEPTH, fifth write overflows and is dropped.
      for (int k = 0; k < 5; k++)
         cyc(1'b1, 10'(2 * k), 1'b1, 10'(32 + 2 * k), 32'(32'hA000 + k));
      idle(5);
      // Forwarding: youngest of two pending writes to the same address.
      cyc(1'b1, 10'h000, 1'b1, 10'h010, 32'hDEAD);
      cyc(1'b1, 10'h002, 1'b1, 10'h010, 32'hBEEF);
      cyc(1'b1, 10'h010, 1'b0, 10'h000, 32'h0);
      cyc(1'b1, 10'h012, 1'b0, 10'h000, 32'h0);
      idle(3);
      // Ordering: odd incoming write waits behind an even head.
      cyc(1'b1, 10'h000, 1'b1, 10'h008, 32'h8888);
      cyc(1'b1, 10'h002, 1'b1, 10'h007, 32'h7777);
      idle(3);

      random_cycles(300);

      // Reset mid-operation with three writes pending.
      for (int k = 0; k < 3; k++)
         cyc(1'b1, 10'(2 * k), 1'b1, 10'(64 + 2 * k), 32'(32'hC000 + k));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      rd_en = 1'b0; wr_en = 1'b0;
      #1;
      chk_reset_outputs();
      #1 rst_n = 1'b1;
      model_reset();
      drive(1'b0, 10'h0, 1'b0, 10'h0, 32'h0);
      idle(1);

      random_cycles(300);
      idle(2);

      repeat (2) @(posedge clk);
      #3;
      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
